game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level round sequencer for the countdown timer datapath.
- Runs a 3-2-1 "ready" countdown, then drives the timer's run enable (`game_enable`) and restart pulse (`timer_reset`).
- Handles pause/resume and ends the round on timer expiry (`time_out`) or a stage-clear event.
- Sits between the debounced button pulses / puzzle logic and the timer; its state code feeds the display mux.

Parameters:
- READY_TICK, 50_000_000, clock cycles per ready-countdown step (1 s at 50 MHz); benches override to a small value.
- READY_STEPS, 3, first digit shown in READY (counts READY_STEPS..1); legal range 1..9.
- RESULT_HOLD, 150_000_000, cycles WIN/LOSE is held before auto-return to IDLE; 0 = hold until btn_start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_start  in  1  one-cycle pulse, debounced start/restart request
- btn_pause  in  1  one-cycle pulse, pause/resume toggle
- stage_clear  in  1  one-cycle pulse from puzzle logic, round won
- time_out  in  1  level from timer, high while enabled at 00:00
- game_enable  out  1  timer run enable; high only in PLAY
- timer_reset  out  1  one-cycle pulse reloading the timer to its start time
- state_code  out  3  0 IDLE, 1 READY, 2 PLAY, 3 PAUSE, 4 WIN, 5 LOSE
- ready_digit  out  4  current countdown digit in READY, else 0
- win_pulse  out  1  one-cycle pulse on entry to WIN
- lose_pulse  out  1  one-cycle pulse on entry to LOSE

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; tick counter and step counter cleared. Reset mid-round aborts immediately.
- All outputs are registered; each output reflects the state entered on the same edge.
- IDLE:
  - btn_start -> READY.
  - timer_reset = 1 for exactly the first cycle of READY.
  - ready_digit = READY_STEPS.
- READY:
  - Tick counter counts 0..READY_TICK-1; at terminal count ready_digit decrements.
  - On terminal count with ready_digit == 1 -> PLAY; ready_digit = 0.
  - btn_pause and stage_clear are ignored.
  - READY lasts exactly READY_STEPS*READY_TICK cycles.
- PLAY:
  - game_enable = 1.
  - time_out -> LOSE.
  - stage_clear -> WIN.
  - btn_pause -> PAUSE.
  - Priority when simultaneous: time_out > stage_clear > btn_pause.
  - btn_start ignored.
- PAUSE:
  - game_enable = 0.
  - btn_pause -> PLAY.
  - btn_start -> READY (restart, with timer_reset pulse).
  - If both: btn_start wins.
  - time_out and stage_clear ignored.
- WIN / LOSE:
  - game_enable = 0.
  - win_pulse / lose_pulse high for the first cycle only.
  - Hold counter runs; at RESULT_HOLD-1 -> IDLE.
  - btn_start at any time -> READY with timer_reset pulse.
  - If RESULT_HOLD == 0: no auto-return.
- Counters:
  - Tick counter is 32-bit, cleared on every state entry.
  - Hold counter reuses the tick counter. No wrap: it saturates by state exit.
- game_enable falls on the same edge that enters LOSE/WIN/PAUSE, so the timer sees at most one time_out cycle after expiry.
- Undefined state encodings -> IDLE on the next edge.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE..ST_LOSE, 3-bit);
  - the default clock frequency constant (50_000_000).
- The display mux uses the same encodings.
- One natural sub-module: tick_prescaler (enable, clear, terminal-count pulse, parameter LIMIT). It is reused for both the READY step timing and the result hold.

Test Plan (READY_TICK=10, READY_STEPS=3, RESULT_HOLD=20):
- Reset, then btn_start at cycle 5:
  - state_code=1 and timer_reset=1 for one cycle.
  - ready_digit 3,2,1, each for 10 cycles.
  - state_code=2 and game_enable=1 exactly 30 cycles after READY entry.
- In PLAY, btn_pause, then btn_pause again 7 cycles later:
  - state_code 3, game_enable=0 for 7 cycles, then back to 2.
  - No timer_reset pulse.
- In PLAY, time_out and stage_clear asserted in the same cycle:
  - Next cycle state_code=5, lose_pulse=1 for one cycle, win_pulse stays 0.
  - IDLE 20 cycles later.
- In PLAY, stage_clear pulse:
  - state_code=4, win_pulse one cycle.
  - btn_start at hold cycle 8 -> READY with timer_reset=1, ready_digit=3.
- In PAUSE, btn_start and btn_pause in the same cycle:
  - READY entered, timer_reset pulses, game_enable stays 0.
- rst_n driven low mid-READY (ready_digit=2) between clock edges:
  - All outputs 0 and state_code=0 immediately (asynchronously).
  - After release, btn_start restarts the countdown from 3.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the round sequencer and the display mux that decodes its state code.
package game_flow_ctrl_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_e;

endpackage

// File: rtl/game_flow_ctrl_tick.sv
// Free-running 32-bit prescaler: tc is high on the last cycle of each LIMIT-cycle period.
module tick_prescaler
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = CLK_FREQ_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  // LIMIT == 0 disables the terminal count; the counter then saturates instead of wrapping.
  localparam logic [31:0] LAST = (LIMIT == 0) ? '0 : 32'(LIMIT - 1);

  logic [31:0] cnt;

  assign tc = en && (LIMIT != 0) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: ready countdown, play/pause, and win/lose result hold driving the countdown timer.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned READY_TICK  = CLK_FREQ_HZ,
  parameter int unsigned READY_STEPS = 3,
  parameter int unsigned RESULT_HOLD = 3 * CLK_FREQ_HZ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       stage_clear,
  input  logic       time_out,
  output logic       game_enable,
  output logic       timer_reset,
  output logic [2:0] state_code,
  output logic [3:0] ready_digit,
  output logic       win_pulse,
  output logic       lose_pulse
);

  state_e state, nxt;
  logic   ready_en, hold_en;
  logic   ready_tc, hold_tc;

  // Counters run only while in their state, so they are already zero on every entry.
  assign ready_en = (state == ST_READY);
  assign hold_en  = (state == ST_WIN) || (state == ST_LOSE);

  tick_prescaler #(.LIMIT(READY_TICK)) u_ready_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ready_en),
    .clr   (!ready_en),
    .tc    (ready_tc)
  );

  tick_prescaler #(.LIMIT(RESULT_HOLD)) u_hold_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hold_en),
    .clr   (!hold_en),
    .tc    (hold_tc)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (btn_start) nxt = ST_READY;
      ST_READY: if (ready_tc && ready_digit == 4'd1) nxt = ST_PLAY;
      ST_PLAY: begin
        if (time_out)         nxt = ST_LOSE;
        else if (stage_clear) nxt = ST_WIN;
        else if (btn_pause)   nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_start)      nxt = ST_READY;
        else if (btn_pause) nxt = ST_PLAY;
      end
      ST_WIN, ST_LOSE: begin
        if (btn_start)    nxt = ST_READY;
        else if (hold_tc) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      game_enable <= 1'b0;
      timer_reset <= 1'b0;
      ready_digit <= '0;
      win_pulse   <= 1'b0;
      lose_pulse  <= 1'b0;
    end else begin
      state       <= nxt;
      game_enable <= (nxt == ST_PLAY);
      timer_reset <= (nxt == ST_READY) && (state != ST_READY);
      win_pulse   <= (nxt == ST_WIN) && (state != ST_WIN);
      lose_pulse  <= (nxt == ST_LOSE) && (state != ST_LOSE);
      if (nxt != ST_READY)
        ready_digit <= '0;
      else if (state != ST_READY)
        ready_digit <= 4'(READY_STEPS);
      else if (ready_tc)
        ready_digit <= ready_digit - 4'd1;
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a cycle-age reference model queues expected outputs per edge.
module tb_game_flow_ctrl;

  localparam int TICK  = 10;
  localparam int STEPS = 3;
  localparam int HOLD  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, stage_clear = 1'b0, time_out = 1'b0;
  logic       game_enable, timer_reset, win_pulse, lose_pulse;
  logic [2:0] state_code;
  logic [3:0] ready_digit;

  game_flow_ctrl #(
    .READY_TICK  (TICK),
    .READY_STEPS (STEPS),
    .RESULT_HOLD (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .stage_clear (stage_clear),
    .time_out    (time_out),
    .game_enable (game_enable),
    .timer_reset (timer_reset),
    .state_code  (state_code),
    .ready_digit (ready_digit),
    .win_pulse   (win_pulse),
    .lose_pulse  (lose_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ge;
    int tr;
    int wp;
    int lp;
    int rd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: phase code plus cycles spent in that phase.
  int m_st = 0;
  int m_age = 0;
  bit m_entered = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic enter(input int s);
    m_st = s;
    m_age = 0;
    m_entered = 1'b1;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p, input bit c, input bit t);
    m_entered = 1'b0;
    if (!r) begin
      m_st = 0;
      m_age = 0;
    end else begin
      case (m_st)
        0: if (s) enter(1);
        1: if (m_age == STEPS * TICK - 1) enter(2); else m_age++;
        2: if (t) enter(5); else if (c) enter(4); else if (p) enter(3); else m_age++;
        3: if (s) enter(1); else if (p) enter(2); else m_age++;
        default: if (s) enter(1); else if (HOLD != 0 && m_age == HOLD - 1) enter(0); else m_age++;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit c, input bit t);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    btn_start = s;
    btn_pause = p;
    stage_clear = c;
    time_out = t;
    model_edge(r, s, p, c, t);
    e.st = m_st;
    e.ge = (m_st == 2) ? 1 : 0;
    e.tr = (m_entered && m_st == 1) ? 1 : 0;
    e.wp = (m_entered && m_st == 4) ? 1 : 0;
    e.lp = (m_entered && m_st == 5) ? 1 : 0;
    e.rd = (m_st == 1) ? STEPS - m_age / TICK : 0;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int st);
    for (int i = 0; i < 200 && m_st != st; i++) step(1, 0, 0, 0, 0);
    if (m_st != st) chk("run_until_bound", m_st, st);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state_code", int'(state_code), e.st);
      chk("game_enable", int'(game_enable), e.ge);
      chk("timer_reset", int'(timer_reset), e.tr);
      chk("win_pulse", int'(win_pulse), e.wp);
      chk("lose_pulse", int'(lose_pulse), e.lp);
      chk("ready_digit", int'(ready_digit), e.rd);
    end
  end

  initial begin
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    run_until(2);
    idle(3);

    // Pause for seven cycles and resume.
    step(1, 0, 1, 0, 0);
    idle(6);
    step(1, 0, 1, 0, 0);
    idle(2);

    // time_out and stage_clear together: lose wins.
    step(1, 0, 0, 1, 1);
    idle(25);

    // Win, then restart partway through the hold.
    step(1, 1, 0, 0, 0);
    run_until(2);
    step(1, 0, 0, 1, 0);
    idle(7);
    step(1, 1, 0, 0, 0);
    run_until(2);

    // Start and pause together while paused: restart.
    step(1, 0, 1, 0, 0);
    idle(2);
    step(1, 1, 1, 0, 0);
    idle(TICK + 3);

    // Async reset between edges while digit 2 is shown.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_state_code", int'(state_code), 0);
    chk("async_ready_digit", int'(ready_digit), 0);
    chk("async_game_enable", int'(game_enable), 0);
    chk("async_timer_reset", int'(timer_reset), 0);
    chk("async_pulses", int'({win_pulse, lose_pulse}), 0);
    m_st = 0;
    m_age = 0;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    run_until(2);

    // Randomised traffic, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 24) == 0));
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
